// File: rtl/warmboot_sequencer.sv
// rtl/warmboot_sequencer.sv - USB bootloader power-up and warm-boot sequencer
//
// Holds the bootloader core in reset until the PLL is locked and settled.
// On a boot request it detaches USB, parks the SPI bus, presents the image
// select to SB_WARMBOOT and then fires BOOT.
//
// Ports:
//   clk_48mhz   in   sole clock (PLL global output)
//   reset       in   synchronous, active-high
//   pll_lock    in   PLL LOCK, asynchronous, double-flopped here
//   boot_req    in   boot request, rising edge acted on in RUN only
//   image_sel   in   warm-boot image index, sampled on accepted request
//   core_reset  out  reset to the bootloader core, active-high
//   usb_detach  out  forces USB pads detached
//   spi_park    out  parks the SPI flash bus
//   wb_s1/wb_s0 out  SB_WARMBOOT image select
//   wb_boot     out  SB_WARMBOOT BOOT
//   busy        out  high in every state except RUN
module warmboot_sequencer #(
    parameter int         SETTLE_CYCLES = 4800,
    parameter int         DETACH_CYCLES = 480000,
    parameter int         ARM_CYCLES    = 16,
    parameter logic [1:0] DEFAULT_IMAGE = 2'b01
) (
    input  logic       clk_48mhz,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       boot_req,
    input  logic [1:0] image_sel,
    output logic       core_reset,
    output logic       usb_detach,
    output logic       spi_park,
    output logic       wb_s1,
    output logic       wb_s0,
    output logic       wb_boot,
    output logic       busy
);

    localparam int MAX_SD     = (SETTLE_CYCLES > DETACH_CYCLES) ? SETTLE_CYCLES : DETACH_CYCLES;
    localparam int MAX_CYCLES = (MAX_SD > ARM_CYCLES) ? MAX_SD : ARM_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] DETACH_LAST = CW'(DETACH_CYCLES - 1);
    localparam logic [CW-1:0] ARM_LAST    = CW'(ARM_CYCLES - 1);

    typedef enum logic [2:0] {
        S_HOLD,
        S_SETTLE,
        S_RUN,
        S_DETACH,
        S_ARM,
        S_BOOT
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] count;
    logic [CW-1:0] count_n;
    logic          count_en;
    logic [1:0]    img_q;
    logic [1:0]    img_n;
    logic          lock_meta;
    logic          lock_s;
    logic          boot_req_q;
    logic          boot_edge;

    logic          core_reset_n;
    logic          detach_n;
    logic [1:0]    sel_n;
    logic          wb_boot_n;
    logic          busy_n;

    assign boot_edge = boot_req & ~boot_req_q;

    always_comb begin
        state_n  = state;
        img_n    = img_q;
        count_en = 1'b0;
        case (state)
            S_HOLD: begin
                if (lock_s) state_n = S_SETTLE;
            end
            S_SETTLE: begin
                count_en = 1'b1;
                if (!lock_s)                    state_n = S_HOLD;
                else if (count == SETTLE_LAST)  state_n = S_RUN;
            end
            S_RUN: begin
                // Lock loss takes priority; a simultaneous request is dropped.
                if (!lock_s) begin
                    state_n = S_HOLD;
                end else if (boot_edge) begin
                    img_n   = image_sel;
                    state_n = S_DETACH;
                end
            end
            S_DETACH: begin
                count_en = 1'b1;
                if (count == DETACH_LAST) state_n = S_ARM;
            end
            S_ARM: begin
                count_en = 1'b1;
                if (count == ARM_LAST) state_n = S_BOOT;
            end
            S_BOOT: begin
                state_n = S_BOOT;
            end
            default: begin
                state_n = S_HOLD;
            end
        endcase

        // Counter restarts at 0 on every state entry.
        if (state_n != state) count_n = '0;
        else if (count_en)    count_n = count + CW'(1);
        else                  count_n = count;

        // Outputs are decoded from the next state so they register alongside it.
        core_reset_n = (state_n == S_HOLD) || (state_n == S_SETTLE);
        detach_n     = (state_n == S_DETACH) || (state_n == S_ARM) || (state_n == S_BOOT);
        sel_n        = ((state_n == S_ARM) || (state_n == S_BOOT)) ? img_n : DEFAULT_IMAGE;
        wb_boot_n    = (state_n == S_BOOT);
        busy_n       = (state_n != S_RUN);
    end

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state      <= S_HOLD;
            count      <= '0;
            img_q      <= DEFAULT_IMAGE;
            lock_meta  <= 1'b0;
            lock_s     <= 1'b0;
            boot_req_q <= 1'b0;
            core_reset <= 1'b1;
            usb_detach <= 1'b0;
            spi_park   <= 1'b0;
            wb_s1      <= DEFAULT_IMAGE[1];
            wb_s0      <= DEFAULT_IMAGE[0];
            wb_boot    <= 1'b0;
            busy       <= 1'b1;
        end else begin
            state      <= state_n;
            count      <= count_n;
            img_q      <= img_n;
            lock_meta  <= pll_lock;
            lock_s     <= lock_meta;
            boot_req_q <= boot_req;
            core_reset <= core_reset_n;
            usb_detach <= detach_n;
            spi_park   <= detach_n;
            wb_s1      <= sel_n[1];
            wb_s0      <= sel_n[0];
            wb_boot    <= wb_boot_n;
            busy       <= busy_n;
        end
    end

endmodule

// File: tb/tb_warmboot_sequencer.sv
// tb/tb_warmboot_sequencer.sv - scoreboard bench for warmboot_sequencer
module tb_warmboot_sequencer;

    localparam int         SETTLE = 8;
    localparam int         DETACH = 20;
    localparam int         ARM    = 4;
    localparam logic [1:0] DEF    = 2'b01;

    localparam int PH_HOLD = 0, PH_SETTLE = 1, PH_RUN = 2, PH_DETACH = 3, PH_ARM = 4, PH_BOOT = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       boot_req;
    logic [1:0] image_sel;
    logic       core_reset, usb_detach, spi_park, wb_s1, wb_s0, wb_boot, busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] exp_q [$];
    longint     exp_cyc_q [$];

    // Reference model: phase plus absolute deadline edge, not a counter.
    int         m_ph;
    longint     m_cyc;
    longint     m_deadline;
    logic [1:0] m_img;
    bit         m_l1, m_l2, m_pbr;

    warmboot_sequencer #(
        .SETTLE_CYCLES(SETTLE),
        .DETACH_CYCLES(DETACH),
        .ARM_CYCLES   (ARM),
        .DEFAULT_IMAGE(DEF)
    ) dut (
        .clk_48mhz (clk),
        .reset     (reset),
        .pll_lock  (pll_lock),
        .boot_req  (boot_req),
        .image_sel (image_sel),
        .core_reset(core_reset),
        .usb_detach(usb_detach),
        .spi_park  (spi_park),
        .wb_s1     (wb_s1),
        .wb_s0     (wb_s0),
        .wb_boot   (wb_boot),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic enter(input int ph, input int n);
        m_ph       = ph;
        m_deadline = m_cyc + n;
    endtask

    // Advance the model by one clock edge using the inputs sampled at that edge.
    task automatic model_step(input bit r, input bit lk, input bit br, input logic [1:0] is);
        bit ls;
        bit req_edge;
        ls       = m_l2;
        req_edge = br && !m_pbr;
        if (r) begin
            m_ph  = PH_HOLD;
            m_l1  = 0;
            m_l2  = 0;
            m_pbr = 0;
            m_img = DEF;
        end else begin
            m_l2  = m_l1;
            m_l1  = lk;
            m_pbr = br;
            case (m_ph)
                PH_HOLD:   if (ls) enter(PH_SETTLE, SETTLE);
                PH_SETTLE: if (!ls) m_ph = PH_HOLD;
                           else if (m_cyc == m_deadline) m_ph = PH_RUN;
                PH_RUN:    if (!ls) m_ph = PH_HOLD;
                           else if (req_edge) begin
                               m_img = is;
                               enter(PH_DETACH, DETACH);
                           end
                PH_DETACH: if (m_cyc == m_deadline) enter(PH_ARM, ARM);
                PH_ARM:    if (m_cyc == m_deadline) m_ph = PH_BOOT;
                default:   ;
            endcase
        end
        m_cyc++;
    endtask

    function automatic logic [6:0] model_out();
        logic [1:0] s;
        s = (m_ph >= PH_ARM) ? m_img : DEF;
        return {m_ph <= PH_SETTLE, m_ph >= PH_DETACH, m_ph >= PH_DETACH,
                s[1], s[0], m_ph == PH_BOOT, m_ph != PH_RUN};
    endfunction

    // Monitor: pops one expectation per cycle and compares.
    initial begin
        logic [6:0] e, a;
        longint     c;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                a = {core_reset, usb_detach, spi_park, wb_s1, wb_s0, wb_boot, busy};
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs edge %0d {rst,det,park,s1,s0,boot,busy}: got %b expected %b",
                             c, a, e);
                end
            end
        end
    end

    initial begin
        bit lock_lvl;
        int lock_at;
        m_ph       = PH_HOLD;
        m_cyc      = 0;
        m_deadline = 0;
        m_img      = DEF;
        m_l1       = 0;
        m_l2       = 0;
        m_pbr      = 0;
        reset      = 1'b1;
        pll_lock   = 1'b0;
        boot_req   = 1'b0;
        image_sel  = 2'b00;
        lock_lvl   = 0;
        lock_at    = 5;

        for (int sc = 0; sc < 25; sc++) begin
            lock_lvl = 0;
            lock_at  = (sc == 0) ? 10 : int'($urandom_range(2, 15));
            for (int i = 0; i < 160; i++) begin
                @(posedge clk);
                #1;
                model_step(reset, pll_lock, boot_req, image_sel);
                exp_q.push_back(model_out());
                exp_cyc_q.push_back(m_cyc);
                // Drive inputs for the cycle that ends at the next edge.
                if (sc == 0) begin
                    reset     = (i < 2);
                    pll_lock  = (i >= 9);
                    boot_req  = (i == 49);
                    image_sel = (i <= 49) ? 2'b11 : 2'b00;
                end else begin
                    reset = (i < 2) || ($urandom_range(0, 119) == 0);
                    if (i >= lock_at) lock_lvl = 1;
                    pll_lock = lock_lvl && ($urandom_range(0, 24) != 0);
                    if ($urandom_range(0, 5) == 0) boot_req = ~boot_req;
                    image_sel = 2'($urandom);
                end
            end
        end

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
